qspi_mem_ctrl: RTL

// - Quad-SPI (QPI-mode PSRAM/flash) master beneath the mmu. Converts one 32-bit word request

---
 rtl/qspi_pkg.sv | 39 +++
 rtl/qspi_sck_gen.sv | 36 +++
 rtl/qspi_mem_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/qspi_pkg.sv
// Shared QPI command opcodes, controller state encoding and small request-decoding helpers
// for the QSPI memory controller.
package qspi_pkg;

  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DESEL} qspi_state_e;

  typedef struct packed {
    logic       ok;   // non-empty, contiguous byte-enable mask
    logic [1:0] lo;   // lowest enabled byte index
    logic [2:0] cnt;  // number of enabled bytes
  } be_info_t;

  function automatic be_info_t be_decode(input logic [3:0] be);
    be_info_t r;
    r = '0;
    case (be)
      4'b0001: r = {1'b1, 2'd0, 3'd1};
      4'b0010: r = {1'b1, 2'd1, 3'd1};
      4'b0100: r = {1'b1, 2'd2, 3'd1};
      4'b1000: r = {1'b1, 2'd3, 3'd1};
      4'b0011: r = {1'b1, 2'd0, 3'd2};
      4'b0110: r = {1'b1, 2'd1, 3'd2};
      4'b1100: r = {1'b1, 2'd2, 3'd2};
      4'b0111: r = {1'b1, 2'd0, 3'd3};
      4'b1110: r = {1'b1, 2'd1, 3'd3};
      4'b1111: r = {1'b1, 2'd0, 3'd4};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/qspi_sck_gen.sv
// SPI mode-0 clock generator: sck low for CLK_DIV clk cycles, then high for CLK_DIV,
// with one-cycle pulses marking the rising edge (sample) and falling edge (shift).
module qspi_sck_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck_o,
  output logic shift_o,
  output logic sample_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          half_end;

  assign half_end = en && (cnt == LAST);
  assign sample_o = half_end && !sck_o;
  assign shift_o  = half_end && sck_o;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt   <= '0;
      sck_o <= 1'b0;
    end else if (half_end) begin
      cnt   <= '0;
      sck_o <= ~sck_o;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/qspi_mem_ctrl.sv
// QPI master: turns one 32-bit word request into a 0xEB read or 0x38 write frame,
// nibble-serialised on split io_o / io_oe / io_i pads.
module qspi_mem_ctrl
  import qspi_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int CLK_DIV   = 1,
  parameter int DUMMY_CYC = 6,
  parameter int CS_HOLD   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  input  logic [3:0]        qspi_io_i,
  output logic [3:0]        qspi_io_o,
  output logic [3:0]        qspi_io_oe_o,
  output logic              qspi_ck_o,
  output logic              qspi_cs_o
);

  localparam int TX_W = 8 + ADDR_W + 32;
  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_W / 4 - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

  qspi_state_e     state_q, state_d;
  logic [7:0]      slot_q;
  logic [TX_W-1:0] tx_q;
  logic [31:0]     rx_q;
  logic            we_q;
  logic            bad_q;
  logic [3:0]      data_last_q;
  logic            en, shift, sample, accept, oe;
  logic            addr_lsb_unused;
  be_info_t        be_info;

  assign be_info         = be_decode(be_i);
  assign gnt_o           = (state_q == IDLE);
  assign accept          = req_i && gnt_o;
  assign en              = state_q inside {CMD, ADDR, DUMMY, DATA};
  assign oe              = (state_q inside {CMD, ADDR}) || (state_q == DATA && we_q);
  assign qspi_cs_o       = ~en;
  assign qspi_io_oe_o    = {4{oe}};
  assign qspi_io_o       = tx_q[TX_W-1 -: 4];
  assign addr_lsb_unused = ^addr_i[1:0];

  qspi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sck_o    (qspi_ck_o),
    .shift_o  (shift),
    .sample_o (sample)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Bad write masks skip the bus entirely and go straight to a one-cycle error response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = (we_i && !be_info.ok) ? DESEL : CMD;
      CMD:   if (shift && slot_q == 8'd1) state_d = ADDR;
      ADDR:  if (shift && slot_q == ADDR_LAST)
               state_d = (we_q || DUMMY_CYC == 0) ? DATA : DUMMY;
      DUMMY: if (shift && slot_q == DUMMY_LAST) state_d = DATA;
      DATA:  if (shift && slot_q == {4'd0, data_last_q}) state_d = DESEL;
      DESEL: if (bad_q || slot_q == HOLD_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= '0;
      tx_q        <= '0;
      we_q        <= 1'b0;
      bad_q       <= 1'b0;
      data_last_q <= '0;
      rvalid_o    <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= '0;
    end else begin
      rvalid_o <= 1'b0;
      if (state_d != state_q)
        slot_q <= '0;
      else if (shift || state_q == DESEL)
        slot_q <= slot_q + 8'd1;

      // Write bytes are pre-shifted so the lowest enabled byte leaves first, high nibble first.
      if (accept) begin
        we_q        <= we_i;
        bad_q       <= we_i && !be_info.ok;
        data_last_q <= we_i ? ({be_info.cnt, 1'b0} - 4'd1) : 4'd7;
        tx_q        <= {(we_i ? CMD_QWRITE : CMD_QREAD), addr_i[ADDR_W-1:2],
                        (we_i ? be_info.lo : 2'b00),
                        swap32(wdata_i >> {be_info.lo, 3'b000})};
      end else if (shift) begin
        tx_q <= tx_q << 4;
      end

      if (state_q != DESEL && state_d == DESEL) begin
        rvalid_o <= 1'b1;
        err_o    <= (state_q == IDLE);
        if (state_q == DATA && !we_q) rdata_o <= swap32(rx_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sample && state_q == DATA && !we_q) rx_q <= {rx_q[27:0], qspi_io_i};
  end

endmodule
